bn_param_sequencer: RTL and testbench
=====================================

Name: bn_param_sequencer

Overview:
- Upstream feeder for the INT8 batch-norm stage.
- Accepts a channel-major activation stream over valid/ready and looks up per-channel mean/var/gamma/beta from a local parameter table.
- Drives the batch-norm enable, data and parameter inputs with the per-stage skew that stage requires: gamma consumed one enable later than data, beta two enables later.
- After the last element, issues flush enables so the final results drain out of the batch-norm pipeline.

Parameters:
- DATA_WIDTH, 8, element and parameter width (signed).
- MAX_CH, 16, parameter-table depth (channels).
- CH_W, $clog2(MAX_CH), channel index width.
- PLANE_W, 16, width of the elements-per-channel count.
- FLUSH_EN, 4, number of flush enables issued after the last element (the batch-norm pipeline depth).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- pw_en  in  1  parameter write strobe
- pw_ch  in  CH_W  channel to write
- pw_sel  in  2  field select: 0=mean, 1=var, 2=gamma, 3=beta
- pw_data  in  DATA_WIDTH  value written
- pw_err  out  1  1-cycle pulse: write rejected
- start  in  1  1-cycle frame start pulse
- cfg_num_ch  in  CH_W+1  channels in frame (1..MAX_CH)
- cfg_plane  in  PLANE_W  elements per channel (>=1)
- cfg_err  out  1  1-cycle pulse: bad configuration at start
- busy  out  1  high from accepted start until done
- done  out  1  1-cycle pulse when frame complete
- s_valid  in  1  input element valid
- s_ready  out  1  sequencer ready
- s_data  in  DATA_WIDTH  signed input element
- bn_en  out  1  batch-norm enable
- bn_data, bn_mean, bn_var, bn_gamma, bn_beta  out  DATA_WIDTH each  batch-norm operands
- bn_flush  out  1  high on flush enables; results from these are don't-care

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0. The parameter table is not reset and its contents are undefined after power-up.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE + start: checks config first.
  - If cfg_num_ch==0, cfg_num_ch>MAX_CH or cfg_plane==0: cfg_err pulse, stay IDLE.
  - Otherwise: latch cfg, clear ch_cnt/pix_cnt, go to RUN, busy=1.
- start outside IDLE is ignored (no error).
- RUN: s_ready=1.
  - On s_valid&&s_ready: registered 1-cycle latency. Next cycle bn_en=1, bn_data=s_data, bn_mean/bn_var=table[ch_cnt].
  - Otherwise bn_en=0 next cycle, and bn_* hold their values.
- Skew: bn_gamma equals the gamma of the element presented on the previous bn_en; bn_beta equals the beta of the element two bn_en earlier.
  - Implemented as 1- and 2-deep channel-index shift registers advanced only on bn_en.
  - Skew registers are cleared to 0 at frame start.
- Counters: pix_cnt increments per accepted beat.
  - At cfg_plane-1, pix_cnt wraps to 0 and ch_cnt increments.
  - On the last element (ch_cnt==cfg_num_ch-1 and pix_cnt==cfg_plane-1): go to FLUSH; s_ready falls the same cycle the beat is accepted (registered transition).
- FLUSH: FLUSH_EN consecutive cycles with bn_en=1, bn_flush=1, bn_data=0, bn_mean=0; the skew pipeline continues to advance. Then go to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Parameter write: accepted only when state==IDLE and pw_ch<MAX_CH, taking effect next cycle. Otherwise pw_err pulses and the table is unchanged.
- pw_en and start in the same cycle in IDLE: the write is applied, and the frame uses the new value.
- Reset mid-frame: immediate return to IDLE, bn_en=0, table retained.
- There is no downstream backpressure; the batch-norm stage is always-accept.

Decomposition:
- Shared package bn_pkg:
  - field-select constants SEL_MEAN/SEL_VAR/SEL_GAMMA/SEL_BETA;
  - FSM state encoding;
  - FLUSH_EN default.
- One natural sub-module: bn_param_table, a 4-field x MAX_CH register file with 1 write port and 3 asynchronous read ports (cur, d1, d2 channel).

Test Plan:
- Table load ch0 {mean=10, var=1, gamma=2, beta=5}, ch1 {mean=-20, gamma=-1, beta=3}; frame cfg_num_ch=2, cfg_plane=2, s_data 20,30,0,-10 back-to-back.
  - bn_data/mean: 20/10, 30/10, 0/-20, -10/-20.
  - bn_gamma lags one enable: 0,2,2,-1.
  - Then 4 flush enables with bn_flush=1.
  - done one cycle after flush.
- Same frame with s_valid toggling every other cycle.
  - bn_en only on the cycle after each accepted beat.
  - gamma/beta skew is counted in enables, not cycles.
- start with cfg_plane=0: cfg_err=1 for one cycle, busy stays 0, s_ready=0.
- pw_en during RUN (pw_ch=0, mean=99): pw_err pulses; mean for ch0 stays 10 for the rest of the frame.
- rst_n asserted after the second beat:
  - bn_en, busy and s_ready drop asynchronously;
  - a new start then reproduces identical outputs with table values intact.
- cfg_num_ch=MAX_CH, cfg_plane=1: ch_cnt reaches 15, exactly 16 data enables plus 4 flush enables, single done pulse.

Source files
------------

// File: rtl/bn_pkg.sv
// Shared definitions for the batch-norm parameter sequencer slice.
package bn_pkg;

    // Parameter-table field selects
    localparam logic [1:0] SEL_MEAN  = 2'd0;
    localparam logic [1:0] SEL_VAR   = 2'd1;
    localparam logic [1:0] SEL_GAMMA = 2'd2;
    localparam logic [1:0] SEL_BETA  = 2'd3;

    // Default batch-norm pipeline depth (flush enables after last element)
    localparam int FLUSH_EN_DEF = 4;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bn_param_table.sv
// Per-channel mean/var/gamma/beta register file: one write port, three
// asynchronous read ports (current channel, one-enable-delayed channel,
// two-enable-delayed channel). Contents are intentionally not reset.
module bn_param_table
    import bn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_CH     = 16,
    parameter int CH_W       = $clog2(MAX_CH)
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [CH_W-1:0]              wr_ch_i,
    input  logic [1:0]                   wr_sel_i,
    input  logic signed [DATA_WIDTH-1:0] wr_data_i,
    input  logic [CH_W-1:0]              cur_ch_i,
    input  logic [CH_W-1:0]              d1_ch_i,
    input  logic [CH_W-1:0]              d2_ch_i,
    output logic signed [DATA_WIDTH-1:0] mean_o,
    output logic signed [DATA_WIDTH-1:0] var_o,
    output logic signed [DATA_WIDTH-1:0] gamma_o,
    output logic signed [DATA_WIDTH-1:0] beta_o
);

    logic signed [DATA_WIDTH-1:0] mean_q  [MAX_CH];
    logic signed [DATA_WIDTH-1:0] var_q   [MAX_CH];
    logic signed [DATA_WIDTH-1:0] gamma_q [MAX_CH];
    logic signed [DATA_WIDTH-1:0] beta_q  [MAX_CH];

    // Single write port, field chosen by select
    always_ff @(posedge clk) begin
        if (we_i) begin
            case (wr_sel_i)
                SEL_MEAN:  mean_q[wr_ch_i]  <= wr_data_i;
                SEL_VAR:   var_q[wr_ch_i]   <= wr_data_i;
                SEL_GAMMA: gamma_q[wr_ch_i] <= wr_data_i;
                default:   beta_q[wr_ch_i]  <= wr_data_i;
            endcase
        end
    end

    assign mean_o  = mean_q[cur_ch_i];
    assign var_o   = var_q[cur_ch_i];
    assign gamma_o = gamma_q[d1_ch_i];
    assign beta_o  = beta_q[d2_ch_i];

endmodule

// File: rtl/bn_param_sequencer.sv
// Upstream feeder for the INT8 batch-norm stage: accepts a channel-major
// activation stream, attaches per-channel parameters with the gamma/beta
// enable skew the stage expects, then flushes the stage pipeline.
module bn_param_sequencer
    import bn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_CH     = 16,
    parameter int CH_W       = $clog2(MAX_CH),
    parameter int PLANE_W    = 16,
    parameter int FLUSH_EN   = FLUSH_EN_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pw_en,
    input  logic [CH_W-1:0]              pw_ch,
    input  logic [1:0]                   pw_sel,
    input  logic signed [DATA_WIDTH-1:0] pw_data,
    output logic                         pw_err,
    input  logic                         start,
    input  logic [CH_W:0]                cfg_num_ch,
    input  logic [PLANE_W-1:0]           cfg_plane,
    output logic                         cfg_err,
    output logic                         busy,
    output logic                         done,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    output logic                         bn_en,
    output logic signed [DATA_WIDTH-1:0] bn_data,
    output logic signed [DATA_WIDTH-1:0] bn_mean,
    output logic signed [DATA_WIDTH-1:0] bn_var,
    output logic signed [DATA_WIDTH-1:0] bn_gamma,
    output logic signed [DATA_WIDTH-1:0] bn_beta,
    output logic                         bn_flush
);

    localparam int FL_W = $clog2(FLUSH_EN + 1);

    state_t                       state_q, state_d;
    logic [CH_W-1:0]              ch_cnt_q, ch_cnt_d;
    logic [PLANE_W-1:0]           pix_cnt_q, pix_cnt_d;
    logic [CH_W:0]                num_ch_q, num_ch_d;
    logic [PLANE_W-1:0]           plane_q, plane_d;
    logic [FL_W-1:0]              fl_cnt_q, fl_cnt_d;
    logic [CH_W-1:0]              d1_ch_q, d1_ch_d, d2_ch_q, d2_ch_d;
    logic                         d1_v_q, d1_v_d, d2_v_q, d2_v_d;
    logic                         busy_q, busy_d, done_q, done_d;
    logic                         cfg_err_q, cfg_err_d, pw_err_q, pw_err_d;
    logic                         bn_en_q, bn_en_d, bn_flush_q, bn_flush_d;
    logic signed [DATA_WIDTH-1:0] bn_data_q, bn_data_d, bn_mean_q, bn_mean_d;
    logic signed [DATA_WIDTH-1:0] bn_var_q, bn_var_d, bn_gamma_q, bn_gamma_d;
    logic signed [DATA_WIDTH-1:0] bn_beta_q, bn_beta_d;

    logic                         tbl_we, pw_ch_ok;
    logic signed [DATA_WIDTH-1:0] rd_mean, rd_var, rd_gamma, rd_beta;

    // A power-of-two table makes every channel index legal
    if (MAX_CH == (1 << CH_W)) begin : g_ch_full
        assign pw_ch_ok = 1'b1;
    end else begin : g_ch_part
        assign pw_ch_ok = (int'(pw_ch) < MAX_CH);
    end

    bn_param_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_CH     (MAX_CH),
        .CH_W       (CH_W)
    ) u_table (
        .clk       (clk),
        .we_i      (tbl_we),
        .wr_ch_i   (pw_ch),
        .wr_sel_i  (pw_sel),
        .wr_data_i (pw_data),
        .cur_ch_i  (ch_cnt_q),
        .d1_ch_i   (d1_ch_q),
        .d2_ch_i   (d2_ch_q),
        .mean_o    (rd_mean),
        .var_o     (rd_var),
        .gamma_o   (rd_gamma),
        .beta_o    (rd_beta)
    );

    // State, counters and registered batch-norm operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ch_cnt_q   <= '0;
            pix_cnt_q  <= '0;
            num_ch_q   <= '0;
            plane_q    <= '0;
            fl_cnt_q   <= '0;
            d1_ch_q    <= '0;
            d2_ch_q    <= '0;
            d1_v_q     <= 1'b0;
            d2_v_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            pw_err_q   <= 1'b0;
            bn_en_q    <= 1'b0;
            bn_flush_q <= 1'b0;
            bn_data_q  <= '0;
            bn_mean_q  <= '0;
            bn_var_q   <= '0;
            bn_gamma_q <= '0;
            bn_beta_q  <= '0;
        end else begin
            state_q    <= state_d;
            ch_cnt_q   <= ch_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            num_ch_q   <= num_ch_d;
            plane_q    <= plane_d;
            fl_cnt_q   <= fl_cnt_d;
            d1_ch_q    <= d1_ch_d;
            d2_ch_q    <= d2_ch_d;
            d1_v_q     <= d1_v_d;
            d2_v_q     <= d2_v_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            pw_err_q   <= pw_err_d;
            bn_en_q    <= bn_en_d;
            bn_flush_q <= bn_flush_d;
            bn_data_q  <= bn_data_d;
            bn_mean_q  <= bn_mean_d;
            bn_var_q   <= bn_var_d;
            bn_gamma_q <= bn_gamma_d;
            bn_beta_q  <= bn_beta_d;
        end
    end

    // Next-state, counter and operand-load logic
    always_comb begin
        state_d    = state_q;
        ch_cnt_d   = ch_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        num_ch_d   = num_ch_q;
        plane_d    = plane_q;
        fl_cnt_d   = fl_cnt_q;
        d1_ch_d    = d1_ch_q;
        d2_ch_d    = d2_ch_q;
        d1_v_d     = d1_v_q;
        d2_v_d     = d2_v_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        bn_en_d    = 1'b0;
        bn_flush_d = 1'b0;
        bn_data_d  = bn_data_q;
        bn_mean_d  = bn_mean_q;
        bn_var_d   = bn_var_q;
        bn_gamma_d = bn_gamma_q;
        bn_beta_d  = bn_beta_q;

        tbl_we   = pw_en && (state_q == ST_IDLE) && pw_ch_ok;
        pw_err_d = pw_en && !tbl_we;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((cfg_num_ch == '0) || (int'(cfg_num_ch) > MAX_CH) ||
                        (cfg_plane == '0)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        num_ch_d  = cfg_num_ch;
                        plane_d   = cfg_plane;
                        ch_cnt_d  = '0;
                        pix_cnt_d = '0;
                        fl_cnt_d  = '0;
                        d1_ch_d   = '0;
                        d2_ch_d   = '0;
                        d1_v_d    = 1'b0;
                        d2_v_d    = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (s_valid) begin
                    bn_en_d   = 1'b1;
                    bn_data_d = s_data;
                    bn_mean_d = rd_mean;
                    bn_var_d  = rd_var;
                    if (pix_cnt_q == plane_q - 1'b1) begin
                        pix_cnt_d = '0;
                        if ({1'b0, ch_cnt_q} == num_ch_q - 1'b1) begin
                            state_d = ST_FLUSH;
                        end else begin
                            ch_cnt_d = ch_cnt_q + 1'b1;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                bn_en_d    = 1'b1;
                bn_flush_d = 1'b1;
                bn_data_d  = '0;
                bn_mean_d  = '0;
                bn_var_d   = '0;
                if (fl_cnt_q == FL_W'(FLUSH_EN - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    fl_cnt_d = fl_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Skew pipeline advances once per issued enable; a valid bit per
        // stage yields zero gamma/beta until real elements have passed,
        // and flush enables push invalid entries behind the last element.
        if (bn_en_d) begin
            bn_gamma_d = d1_v_q ? rd_gamma : '0;
            bn_beta_d  = d2_v_q ? rd_beta  : '0;
            d1_ch_d    = ch_cnt_q;
            d1_v_d     = !bn_flush_d;
            d2_ch_d    = d1_ch_q;
            d2_v_d     = d1_v_q;
        end
    end

    assign s_ready  = (state_q == ST_RUN);
    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;
    assign pw_err   = pw_err_q;
    assign bn_en    = bn_en_q;
    assign bn_flush = bn_flush_q;
    assign bn_data  = bn_data_q;
    assign bn_mean  = bn_mean_q;
    assign bn_var   = bn_var_q;
    assign bn_gamma = bn_gamma_q;
    assign bn_beta  = bn_beta_q;

endmodule

// File: tb/tb_bn_param_sequencer.sv
// Directed self-checking bench for bn_param_sequencer.
module tb_bn_param_sequencer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pw_en;
    logic [3:0]        pw_ch;
    logic [1:0]        pw_sel;
    logic signed [7:0] pw_data;
    logic              pw_err;
    logic              start;
    logic [4:0]        cfg_num_ch;
    logic [15:0]       cfg_plane;
    logic              cfg_err, busy, done;
    logic              s_valid, s_ready;
    logic signed [7:0] s_data;
    logic              bn_en, bn_flush;
    logic signed [7:0] bn_data, bn_mean, bn_var, bn_gamma, bn_beta;

    int total = 0;
    int bad   = 0;

    // Expected enables for the 2-channel x 2-element frame
    int D [4] = '{20, 30, 0, -10};
    int M [4] = '{10, 10, -20, -20};
    int G [4] = '{0, 2, 2, -1};
    int B [4] = '{0, 0, 5, 5};
    // Expected gamma/beta on the four flush enables
    int FG[4] = '{-1, 0, 0, 0};
    int FB[4] = '{3, 3, 0, 0};

    bn_param_sequencer #(
        .DATA_WIDTH (8),
        .MAX_CH     (16),
        .CH_W       (4),
        .PLANE_W    (16),
        .FLUSH_EN   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pw_en      (pw_en),
        .pw_ch      (pw_ch),
        .pw_sel     (pw_sel),
        .pw_data    (pw_data),
        .pw_err     (pw_err),
        .start      (start),
        .cfg_num_ch (cfg_num_ch),
        .cfg_plane  (cfg_plane),
        .cfg_err    (cfg_err),
        .busy       (busy),
        .done       (done),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .bn_en      (bn_en),
        .bn_data    (bn_data),
        .bn_mean    (bn_mean),
        .bn_var     (bn_var),
        .bn_gamma   (bn_gamma),
        .bn_beta    (bn_beta),
        .bn_flush   (bn_flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pw(input int ch, input int sel, input int val);
        pw_en   = 1'b1;
        pw_ch   = 4'(ch);
        pw_sel  = 2'(sel);
        pw_data = 8'(val);
        tick();
        pw_en = 1'b0;
        chk("pw_ok", pw_err, 0);
    endtask

    // Expected table contents for the full-channel frame
    function automatic int em(int c);
        if (c == 0) return 10;
        if (c == 1) return -20;
        if (c == 15) return 77;
        return c * 4;
    endfunction
    function automatic int eg(int c);
        if (c == 0) return 2;
        if (c == 1) return -1;
        return c;
    endfunction
    function automatic int eb(int c);
        if (c == 0) return 5;
        if (c == 1) return 3;
        return -c;
    endfunction

    // 2ch x 2 frame; gap inserts idle cycles, pw_mid writes during RUN,
    // abort_at>0 applies reset after that many beats
    task automatic frame(input bit gap, input bit pw_mid, input int abort_at);
        start = 1'b1; cfg_num_ch = 5'd2; cfg_plane = 16'd2;
        tick();
        start = 1'b0;
        chk("busy_run", busy, 1);
        chk("ready_run", s_ready, 1);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(D[i]);
            if (pw_mid && i == 0) begin
                pw_en = 1'b1; pw_ch = 4'd0; pw_sel = 2'd0; pw_data = 8'sd99;
            end
            tick();
            pw_en = 1'b0; s_valid = 1'b0;
            if (pw_mid && i == 0) chk("pw_err_run", pw_err, 1);
            chk($sformatf("en%0d", i), bn_en, 1);
            chk($sformatf("flush%0d", i), bn_flush, 0);
            chk($sformatf("data%0d", i), bn_data, D[i]);
            chk($sformatf("mean%0d", i), bn_mean, M[i]);
            chk($sformatf("gamma%0d", i), bn_gamma, G[i]);
            chk($sformatf("beta%0d", i), bn_beta, B[i]);
            chk($sformatf("ready%0d", i), s_ready, (i == 3) ? 0 : 1);
            if (abort_at == i + 1) begin
                rst_n = 1'b0;
                #1;
                chk("rst_en", bn_en, 0);
                chk("rst_busy", busy, 0);
                chk("rst_ready", s_ready, 0);
                #2 rst_n = 1'b1;
                return;
            end
            if (gap && i < 3) begin
                tick();
                chk($sformatf("gap_en%0d", i), bn_en, 0);
                chk($sformatf("gap_data%0d", i), bn_data, D[i]);
                chk($sformatf("gap_gamma%0d", i), bn_gamma, G[i]);
            end
        end
        for (int f = 0; f < 4; f++) begin
            tick();
            chk($sformatf("fl_en%0d", f), bn_en, 1);
            chk($sformatf("fl_flag%0d", f), bn_flush, 1);
            chk($sformatf("fl_data%0d", f), bn_data, 0);
            chk($sformatf("fl_mean%0d", f), bn_mean, 0);
            chk($sformatf("fl_gamma%0d", f), bn_gamma, FG[f]);
            chk($sformatf("fl_beta%0d", f), bn_beta, FB[f]);
            chk($sformatf("fl_done%0d", f), done, 0);
            chk($sformatf("fl_busy%0d", f), busy, 1);
        end
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_en", bn_en, 0);
        tick();
        chk("done_clear", done, 0);
    endtask

    initial begin
        int nfl, nx, nd;
        rst_n = 1'b0; pw_en = 1'b0; pw_ch = '0; pw_sel = '0; pw_data = '0;
        start = 1'b0; cfg_num_ch = '0; cfg_plane = '0; s_valid = 1'b0; s_data = '0;
        tick(); tick();
        chk("rst_bn_en", bn_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_data", bn_data, 0);
        chk("rst_gamma", bn_gamma, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_pw_err", pw_err, 0);
        #2 rst_n = 1'b1;
        tick();

        // Table load
        pw(0, 0, 10); pw(0, 1, 1); pw(0, 2, 2);  pw(0, 3, 5);
        pw(1, 0, -20); pw(1, 1, 4); pw(1, 2, -1); pw(1, 3, 3);

        // Back-to-back, then gapped stream
        frame(1'b0, 1'b0, 0);
        frame(1'b1, 1'b0, 0);

        // Bad configurations
        start = 1'b1; cfg_num_ch = 5'd2; cfg_plane = 16'd0;
        tick();
        start = 1'b0;
        chk("cfgerr_plane", cfg_err, 1);
        chk("cfgerr_busy", busy, 0);
        chk("cfgerr_ready", s_ready, 0);
        tick();
        chk("cfgerr_pulse", cfg_err, 0);
        chk("cfgerr_busy2", busy, 0);
        start = 1'b1; cfg_num_ch = 5'd0; cfg_plane = 16'd1;
        tick();
        start = 1'b0;
        chk("cfgerr_ch0", cfg_err, 1);
        start = 1'b1; cfg_num_ch = 5'd17;
        tick();
        start = 1'b0;
        chk("cfgerr_ch17", cfg_err, 1);
        chk("cfgerr_ch17_busy", busy, 0);
        tick();

        // Write during RUN is rejected; mean stays 10
        frame(1'b0, 1'b1, 0);

        // Reset mid-frame, then identical rerun
        frame(1'b0, 1'b0, 2);
        tick();
        chk("post_rst_busy", busy, 0);
        frame(1'b0, 1'b0, 0);

        // All 16 channels, one element each; ch15 mean written with start
        for (int c = 2; c < 16; c++) begin
            if (c != 15) pw(c, 0, c * 4);
            pw(c, 1, c); pw(c, 2, c); pw(c, 3, -c);
        end
        start = 1'b1; cfg_num_ch = 5'd16; cfg_plane = 16'd1;
        pw_en = 1'b1; pw_ch = 4'd15; pw_sel = 2'd0; pw_data = 8'sd77;
        tick();
        start = 1'b0; pw_en = 1'b0;
        chk("full_pw_start", pw_err, 0);
        chk("full_busy", busy, 1);
        s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = 8'(i + 1);
            tick();
            chk($sformatf("full_en%0d", i), bn_en, 1);
            chk($sformatf("full_data%0d", i), bn_data, i + 1);
            chk($sformatf("full_mean%0d", i), bn_mean, em(i));
            chk($sformatf("full_gamma%0d", i), bn_gamma, (i > 0) ? eg(i - 1) : 0);
            chk($sformatf("full_beta%0d", i), bn_beta, (i > 1) ? eb(i - 2) : 0);
        end
        s_valid = 1'b0;
        chk("full_ready_drop", s_ready, 0);
        nfl = 0; nx = 0; nd = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bn_en && bn_flush) begin
                nfl++;
                if (nfl == 1) begin
                    chk("full_fl_gamma", bn_gamma, 15);
                    chk("full_fl_beta", bn_beta, -14);
                end
            end
            if (bn_en && !bn_flush) nx++;
            if (done) nd++;
        end
        chk("full_flush_count", nfl, 4);
        chk("full_extra_en", nx, 0);
        chk("full_done_count", nd, 1);
        chk("full_busy_end", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
